// File: rtl/datapath2_pkg.sv
// Shared constants for the datapath2 single-bus datapath: ALU opcodes,
// bus-source codes (in priority order), IR field positions and CON condition codes.
package datapath2_pkg;

  localparam int DP_WIDTH     = 32;
  localparam int DP_MEM_DEPTH = 512;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_NEG  = 5'd9;
  localparam logic [4:0] OP_NOT  = 5'd10;
  localparam logic [4:0] OP_MUL  = 5'd11;
  localparam logic [4:0] OP_INC  = 5'd12;

  // Listed highest priority first; SRC_NONE leaves the bus at zero.
  localparam logic [2:0] SRC_NONE = 3'd0;
  localparam logic [2:0] SRC_MBI  = 3'd1;
  localparam logic [2:0] SRC_PC   = 3'd2;
  localparam logic [2:0] SRC_ZLO  = 3'd3;
  localparam logic [2:0] SRC_MDR  = 3'd4;
  localparam logic [2:0] SRC_REG  = 3'd5;
  localparam logic [2:0] SRC_C    = 3'd6;
  localparam logic [2:0] SRC_IN   = 3'd7;

  localparam int IR_RA_LSB  = 23;
  localparam int IR_RB_LSB  = 19;
  localparam int IR_RC_LSB  = 15;
  localparam int IR_C_MSB   = 18;
  localparam int IR_CON_LSB = 19;

  localparam logic [1:0] CON_EQ = 2'd0;
  localparam logic [1:0] CON_NE = 2'd1;
  localparam logic [1:0] CON_GE = 2'd2;
  localparam logic [1:0] CON_LT = 2'd3;

endpackage

// File: rtl/datapath2_if.sv
// Control strobes and data ports of datapath2. The control unit (master) drives
// the strobes; the datapath (slave) returns the output port and CON flag.
interface datapath2_if #(parameter int WIDTH = 32);
  logic PCout, Zlowout, MDRout, MBIout, Rout, BAout, Cout, InPortOut;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn;
  logic Gra, Grb, Grc;
  logic Read, Write;
  logic [4:0]       OpCode;
  logic [WIDTH-1:0] manualBusInput;
  logic [WIDTH-1:0] inport_data;
  logic [WIDTH-1:0] outport_data;
  logic             con_out;

  modport master (
    output PCout, Zlowout, MDRout, MBIout, Rout, BAout, Cout, InPortOut,
    output PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn,
    output Gra, Grb, Grc, Read, Write, OpCode, manualBusInput, inport_data,
    input  outport_data, con_out
  );

  modport slave (
    input  PCout, Zlowout, MDRout, MBIout, Rout, BAout, Cout, InPortOut,
    input  PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn,
    input  Gra, Grb, Grc, Read, Write, OpCode, manualBusInput, inport_data,
    output outport_data, con_out
  );
endinterface

// File: rtl/datapath2_alu.sv
// Combinational ALU: A comes from Y, B from the bus. Opcode 11 (multiply) exists
// only when DATAPATH2_MUL_EN is defined; otherwise it yields 0 like unused codes.
module datapath2_alu
  import datapath2_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic [WIDTH-1:0] y
);
  localparam int SW = $clog2(WIDTH);

  logic [SW:0] sh;
  logic [SW:0] rsh;

  always_comb begin
    sh  = {1'b0, b[SW-1:0]};
    // A complementary shift of WIDTH clears the wrapped half when sh is zero.
    rsh = (SW+1)'(WIDTH) - sh;
    y   = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SHR:  y = a >> sh;
      OP_SHRA: y = $signed(a) >>> sh;
      OP_SHL:  y = a << sh;
      OP_ROR:  y = (a >> sh) | (a << rsh);
      OP_ROL:  y = (a << sh) | (a >> rsh);
      OP_NEG:  y = '0 - b;
      OP_NOT:  y = ~b;
`ifdef DATAPATH2_MUL_EN
      // Low half of a two's-complement product is sign-agnostic.
      OP_MUL:  y = a * b;
`endif
      OP_INC:  y = b + WIDTH'(1);
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/datapath2.sv
// Single-bus datapath with level-sensitive (transparent) registers; clk is not used
// for capture. Optional multiplier enabled by the DATAPATH2_MUL_EN macro.
module datapath2
  import datapath2_pkg::*;
#(
  parameter int WIDTH     = DP_WIDTH,
  parameter int MEM_DEPTH = DP_MEM_DEPTH
) (
  input logic        clk,
  input logic        clr,
  datapath2_if.slave bus_if
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] pc_q, ir_q, mar_q, mdr_q, y_q, z_q, outport_q, inport_q;
  logic [WIDTH-1:0] mdr_d, z_d, c_ext;
  logic [WIDTH-1:0] r_q [16];
  logic [WIDTH-1:0] mem [MEM_DEPTH];
  logic             con_q, con_d;
  logic [3:0]       sel_idx;
  logic [2:0]       bus_src;
  logic             unused_ok;

  assign unused_ok = ^{clk, ir_q[WIDTH-1:IR_RA_LSB+4], mar_q[WIDTH-1:AW]};

  always_comb begin
    sel_idx = 4'd0;
    if (bus_if.Gra)      sel_idx = ir_q[IR_RA_LSB +: 4];
    else if (bus_if.Grb) sel_idx = ir_q[IR_RB_LSB +: 4];
    else if (bus_if.Grc) sel_idx = ir_q[IR_RC_LSB +: 4];
  end

  always_comb begin
    bus_src = SRC_NONE;
    if (bus_if.MBIout)                   bus_src = SRC_MBI;
    else if (bus_if.PCout)               bus_src = SRC_PC;
    else if (bus_if.Zlowout)             bus_src = SRC_ZLO;
    else if (bus_if.MDRout)              bus_src = SRC_MDR;
    else if (bus_if.Rout || bus_if.BAout) bus_src = SRC_REG;
    else if (bus_if.Cout)                bus_src = SRC_C;
    else if (bus_if.InPortOut)           bus_src = SRC_IN;
  end

  assign c_ext = {{(WIDTH-IR_C_MSB-1){ir_q[IR_C_MSB]}}, ir_q[IR_C_MSB:0]};

  always_comb begin
    bus = '0;
    case (bus_src)
      SRC_MBI: bus = bus_if.manualBusInput;
      SRC_PC:  bus = pc_q;
      SRC_ZLO: bus = z_q;
      SRC_MDR: bus = mdr_q;
      // BAout reads R0 as zero (base-address form); Rout always reads the register.
      SRC_REG: bus = (!bus_if.Rout && sel_idx == 4'd0) ? '0 : r_q[sel_idx];
      SRC_C:   bus = c_ext;
      SRC_IN:  bus = inport_q;
      default: bus = '0;
    endcase
  end

  assign mdr_d = bus_if.Read ? mem[mar_q[AW-1:0]] : bus;

  always_comb begin
    con_d = 1'b0;
    case (ir_q[IR_CON_LSB +: 2])
      CON_EQ:  con_d = (bus == '0);
      CON_NE:  con_d = (bus != '0);
      CON_GE:  con_d = ~bus[WIDTH-1];
      CON_LT:  con_d = bus[WIDTH-1];
      default: con_d = 1'b0;
    endcase
  end

  datapath2_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (y_q),
    .b  (bus),
    .op (bus_if.OpCode),
    .y  (z_d)
  );

  always_latch begin
    if (!clr) begin
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      z_q       <= '0;
      outport_q <= '0;
      con_q     <= 1'b0;
    end else begin
      if (bus_if.PCin)      pc_q      <= bus;
      if (bus_if.IRin)      ir_q      <= bus;
      if (bus_if.MARin)     mar_q     <= bus;
      if (bus_if.MDRin)     mdr_q     <= mdr_d;
      if (bus_if.Yin)       y_q       <= bus;
      if (bus_if.Zin)       z_q       <= z_d;
      if (bus_if.OutportIn) outport_q <= bus;
      if (bus_if.CONin)     con_q     <= con_d;
    end
  end

  always_latch begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
    end else if (bus_if.Rin) begin
      r_q[sel_idx] <= bus;
    end
  end

  // Memory is never cleared; it follows MDR for as long as Write is held.
  always_latch begin
    if (bus_if.Write) mem[mar_q[AW-1:0]] <= mdr_q;
  end

  assign inport_q = clr ? bus_if.inport_data : '0;

  assign bus_if.outport_data = outport_q;
  assign bus_if.con_out      = con_q;
endmodule

// File: tb/tb_datapath2.sv
// Bench for datapath2: directed walk-through plus random micro-operations against
// a behavioural model; results are routed to the output port or CON and scored.
module tb_datapath2;
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  datapath2_if dif ();
  datapath2 dut (.clk(clk), .clr(clr), .bus_if(dif));

  localparam int D_PC = 0, D_MAR = 1, D_MDR = 2, D_MDRW = 3, D_IR = 4, D_Y = 5;
  localparam int D_RA = 6, D_RB = 7, D_RC = 8, D_OUT = 9, D_CON = 10;
  localparam int S_PC = 0, S_Z = 1, S_MDR = 2, S_RA = 3, S_RB = 4, S_RC = 5;
  localparam int S_C = 6, S_IN = 7, S_BA_A = 8, S_BA_B = 9;

  logic [31:0] exp_q[$];
  logic        kind_q[$];
  string       name_q[$];
  int checks = 0, errors = 0, pushed = 0, popped = 0;

  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_z;
  logic [31:0] m_r [16];
  logic [31:0] m_mem [512];
  logic        m_con;

  logic [31:0] mon_exp, mon_act;
  logic        mon_kind;
  string       mon_name;

  function automatic logic [3:0] fld(input logic [31:0] ir, input int which);
    if (which == 0) return ir[26:23];
    if (which == 1) return ir[22:19];
    return ir[18:15];
  endfunction

  function automatic logic [31:0] sext19(input logic [31:0] v);
    return v[18] ? {13'h1FFF, v[18:0]} : {13'h0000, v[18:0]};
  endfunction

  function automatic logic cond(input logic [1:0] cc, input logic [31:0] v);
    case (cc)
      2'd0:    return v == 32'd0;
      2'd1:    return v != 32'd0;
      2'd2:    return v[31] == 1'b0;
      default: return v[31] == 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] dbl;
    int s;
    s = int'(b[4:0]);
    dbl = {a, a};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a >> s;
      5'd5:  return 32'($signed(a) >>> s);
      5'd6:  return a << s;
      5'd7:  begin dbl = dbl >> s; return dbl[31:0]; end
      5'd8:  begin dbl = dbl << s; return dbl[63:32]; end
      5'd9:  return 32'd0 - b;
      5'd10: return ~b;
`ifdef DATAPATH2_MUL_EN
      5'd11: return a * b;
`endif
      5'd12: return b + 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_val(input int src);
    case (src)
      S_PC:   return m_pc;
      S_Z:    return m_z;
      S_MDR:  return m_mdr;
      S_RA:   return m_r[fld(m_ir, 0)];
      S_RB:   return m_r[fld(m_ir, 1)];
      S_RC:   return m_r[fld(m_ir, 2)];
      S_C:    return sext19(m_ir);
      S_IN:   return dif.inport_data;
      S_BA_A: return (fld(m_ir, 0) == 4'd0) ? 32'd0 : m_r[fld(m_ir, 0)];
      default: return (fld(m_ir, 1) == 4'd0) ? 32'd0 : m_r[fld(m_ir, 1)];
    endcase
  endfunction

  // Load strobes fall first so every register closes on a stable bus.
  task automatic drop();
    {dif.PCin, dif.MARin, dif.MDRin, dif.IRin, dif.Yin} = '0;
    {dif.Zin, dif.Rin, dif.CONin, dif.OutportIn, dif.Write} = '0;
    #1;
    {dif.PCout, dif.Zlowout, dif.MDRout, dif.MBIout, dif.Rout, dif.BAout} = '0;
    {dif.Cout, dif.InPortOut, dif.Gra, dif.Grb, dif.Grc, dif.Read} = '0;
    dif.OpCode = '0;
    dif.manualBusInput = '0;
    #1;
  endtask

  task automatic step();
    #2;
    drop();
  endtask

  task automatic obs(input logic is_con, input logic [31:0] e, input string name);
    kind_q.push_back(is_con);
    exp_q.push_back(e);
    name_q.push_back(name);
    pushed++;
    for (int k = 0; k < 8 && popped < pushed; k++) @(posedge clk);
    if (popped < pushed) begin
      $display("FAIL %s: monitor never compared, required %h", name, e);
      errors++;
      exp_q.delete(); kind_q.delete(); name_q.delete();
      popped = pushed;
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_kind = kind_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = mon_kind ? {31'd0, dif.con_out} : dif.outport_data;
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got %h, required %h", mon_name, mon_act, mon_exp);
      end
      popped++;
    end
  end

  task automatic mbi_to(input logic [31:0] v, input int dst);
    dif.MBIout = 1'b1;
    dif.manualBusInput = v;
    case (dst)
      D_PC:   begin dif.PCin = 1'b1; m_pc = v; end
      D_MAR:  begin dif.MARin = 1'b1; m_mar = v; end
      D_MDR:  begin dif.MDRin = 1'b1; m_mdr = v; end
      D_MDRW: begin dif.MDRin = 1'b1; dif.Write = 1'b1; m_mdr = v; m_mem[m_mar[8:0]] = v; end
      D_IR:   begin dif.IRin = 1'b1; m_ir = v; end
      D_Y:    begin dif.Yin = 1'b1; m_y = v; end
      D_RA:   begin dif.Gra = 1'b1; dif.Rin = 1'b1; m_r[fld(m_ir, 0)] = v; end
      D_RB:   begin dif.Grb = 1'b1; dif.Rin = 1'b1; m_r[fld(m_ir, 1)] = v; end
      D_RC:   begin dif.Grc = 1'b1; dif.Rin = 1'b1; m_r[fld(m_ir, 2)] = v; end
      D_OUT:  dif.OutportIn = 1'b1;
      default: begin dif.CONin = 1'b1; m_con = cond(m_ir[20:19], v); end
    endcase
    step();
  endtask

  task automatic set_src(input int src);
    case (src)
      S_PC:   dif.PCout = 1'b1;
      S_Z:    dif.Zlowout = 1'b1;
      S_MDR:  dif.MDRout = 1'b1;
      S_RA:   begin dif.Rout = 1'b1; dif.Gra = 1'b1; end
      S_RB:   begin dif.Rout = 1'b1; dif.Grb = 1'b1; end
      S_RC:   begin dif.Rout = 1'b1; dif.Grc = 1'b1; end
      S_C:    dif.Cout = 1'b1;
      S_IN:   dif.InPortOut = 1'b1;
      S_BA_A: begin dif.BAout = 1'b1; dif.Gra = 1'b1; end
      default: begin dif.BAout = 1'b1; dif.Grb = 1'b1; end
    endcase
  endtask

  task automatic showc(input int src, input logic [31:0] e, input string name);
    set_src(src);
    dif.OutportIn = 1'b1;
    step();
    obs(1'b0, e, name);
  endtask

  task automatic show(input int src, input string name);
    showc(src, model_val(src), name);
  endtask

  task automatic alu_mbi(input logic [4:0] op, input logic [31:0] b);
    dif.MBIout = 1'b1; dif.manualBusInput = b; dif.OpCode = op; dif.Zin = 1'b1;
    m_z = ref_alu(op, m_y, b);
    step();
  endtask

  task automatic alu_reg(input logic [4:0] op);
    dif.Rout = 1'b1; dif.Grb = 1'b1; dif.OpCode = op; dif.Zin = 1'b1;
    m_z = ref_alu(op, m_y, m_r[fld(m_ir, 1)]);
    step();
  endtask

  task automatic model_reset();
    {m_pc, m_ir, m_mar, m_mdr, m_y, m_z} = '0;
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_con = 1'b0;
  endtask

  initial begin
    int op;
    logic [31:0] v;
    for (int i = 0; i < 512; i++) m_mem[i] = '0;
    model_reset();
    dif.inport_data = 32'h0BAD_F00D;
    clr = 1'b0;
    drop();
    clr = 1'b1;
    #2;

    // Dirty state so the reset has something to clear.
    mbi_to(32'hB960_0000, D_IR);
    mbi_to(32'h0000_DEAD, D_RA);
    mbi_to(32'h0005_1234, D_IR);
    mbi_to(32'h0000_0077, D_PC);
    mbi_to(32'd3, D_Y);
    alu_mbi(5'd0, 32'd5);
    mbi_to(32'd0, D_CON);
    mbi_to(32'h0000_00AB, D_OUT);
    obs(1'b0, 32'h0000_00AB, "pre_reset_out");
    obs(1'b1, 32'd1, "pre_reset_con");

    clr = 1'b0;
    #2;
    obs(1'b0, 32'd0, "reset_outport");
    obs(1'b1, 32'd0, "reset_con");
    clr = 1'b1;
    model_reset();
    #2;
    showc(S_PC, 32'd0, "reset_pc");
    showc(S_Z, 32'd0, "reset_z");
    showc(S_C, 32'd0, "reset_ir");
    mbi_to(32'hB960_0000, D_IR);
    showc(S_RA, 32'd0, "reset_r2");

    // Directed bring-up and fetch.
    dif.PCin = 1'b1;
    mbi_to(32'd0, D_MAR);
    m_pc = 32'd0;
    mbi_to(32'hB960_0000, D_MDRW);
    dif.MDRout = 1'b1; dif.IRin = 1'b1; step(); m_ir = m_mdr;
    showc(S_MDR, 32'hB960_0000, "mdr_loaded");
    mbi_to(32'd1, D_RA);
    showc(S_RB, 32'd0, "r12_untouched");
    mbi_to(32'h0000_001F, D_MAR);
    mbi_to(32'h1234_5678, D_IR);
    dif.PCout = 1'b1; dif.MARin = 1'b1; dif.Zin = 1'b1; dif.OpCode = 5'd12; step();
    m_mar = m_pc; m_z = m_pc + 32'd1;
    showc(S_Z, 32'd1, "fetch_z");
    dif.Zlowout = 1'b1; dif.PCin = 1'b1; step(); m_pc = m_z;
    showc(S_PC, 32'd1, "fetch_pc");
    dif.Read = 1'b1; dif.MDRin = 1'b1; step(); m_mdr = m_mem[m_mar[8:0]];
    showc(S_MDR, 32'hB960_0000, "fetch_mdr");
    dif.MDRout = 1'b1; dif.IRin = 1'b1; step(); m_ir = m_mdr;
    showc(S_RA, 32'd1, "outport_r2");

    mbi_to(32'd5, D_Y);
    alu_mbi(5'd1, 32'd3);
    showc(S_Z, 32'd2, "alu_sub");
    alu_mbi(5'd9, 32'd3);
    showc(S_Z, 32'hFFFF_FFFD, "alu_neg");
    mbi_to(32'h0008_0000, D_IR);
    mbi_to(32'd0, D_CON);
    obs(1'b1, 32'd0, "con_ne_zero");
    mbi_to(32'd7, D_CON);
    obs(1'b1, 32'd1, "con_ne_seven");

    // Bus priority: a lower-priority source is held alongside a higher one.
    mbi_to(32'h0000_005A, D_RA);
    dif.PCout = 1'b1; mbi_to(32'h0000_0011, D_OUT);
    obs(1'b0, 32'h0000_0011, "prio_mbi_pc");
    dif.Zlowout = 1'b1; showc(S_PC, 32'd1, "prio_pc_z");
    dif.MDRout = 1'b1; showc(S_Z, 32'hFFFF_FFFD, "prio_z_mdr");
    dif.Rout = 1'b1; dif.Gra = 1'b1; showc(S_MDR, 32'hB960_0000, "prio_mdr_r");
    dif.Cout = 1'b1; showc(S_RA, 32'h0000_005A, "prio_r_c");
    dif.InPortOut = 1'b1; showc(S_C, 32'd0, "prio_c_in");
    showc(S_IN, 32'h0BAD_F00D, "inport");
    dif.OutportIn = 1'b1; step(); obs(1'b0, 32'd0, "bus_idle");
    showc(S_BA_A, 32'd0, "baout_r0");

    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: begin mbi_to($urandom, D_IR); show(S_C, "rand_cout"); end
        1: begin mbi_to($urandom, D_RC); show(S_RC, "rand_reg"); end
        2: begin
          mbi_to($urandom, D_Y);
          if ($urandom_range(0, 1) == 1) alu_mbi(5'($urandom_range(0, 15)), $urandom);
          else alu_reg(5'($urandom_range(0, 15)));
          show(S_Z, "rand_alu");
        end
        3: begin
          mbi_to($urandom, D_MAR);
          mbi_to($urandom, D_MDRW);
          mbi_to($urandom, D_MDR);
          dif.Read = 1'b1; dif.MDRin = 1'b1; step(); m_mdr = m_mem[m_mar[8:0]];
          show(S_MDR, "rand_mem");
        end
        4: begin
          v = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
          mbi_to(v, D_CON);
          obs(1'b1, {31'd0, m_con}, "rand_con");
        end
        5: begin dif.inport_data = $urandom; show(S_IN, "rand_inport"); end
        default: begin show(S_BA_B, "rand_baout"); show(S_RB, "rand_rout"); end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/datapath2.md
Name: datapath2

Overview:
- 32-bit single-bus RISC datapath: 16×32 register file with select-and-encode, PC, IR, MAR, MDR, Y, Z, ALU, 512-word memory, CON flip-flop, in/out ports.
- Control strobes come from an external control unit or a bench; nothing is sequenced internally.
- A manual bus-injection path lets a bench preload state.

Parameters:
- MEM_DEPTH, 512, memory words; address = MAR[8:0].
- WIDTH, 32, bus/register width.

Ports:
- clk  in  1  clock (interface only; no capture uses it, see Behaviour).
- clr  in  1  asynchronous active-low reset.
- PCout, Zlowout, MDRout, MBIout, Rout, BAout, Cout, InPortOut  in  1 each  bus-drive strobes.
- PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn  in  1 each  register load strobes.
- Gra, Grb, Grc  in  1 each  register-field select from IR.
- Read, Write  in  1 each  memory read select / write strobe.
- OpCode  in  5  ALU operation.
- manualBusInput  in  32  value driven onto the bus when MBIout=1.
- inport_data  in  32  external input port value.
- outport_data  out  32  output port register.
- con_out  out  1  CON flip-flop.

Behaviour:
- Reset (clr=0, async): PC, IR, MAR, MDR, Y, Z, R0–R15, in/out port registers and CON all clear to 0; memory contents unchanged.
- Storage elements are level-sensitive: each register is transparent while its *in strobe is high and holds when it is low. Control pulses may arrive between clock edges.
- No register may be loaded and driven onto the bus at the same time.
- Bus mux uses this fixed priority when several drivers are high: MBIout > PCout > Zlowout > MDRout > Rout/BAout > Cout > InPortOut. Bus = 0 when none is high.
- MDR input = memory[MAR] when Read=1, else bus.
- Memory: while Write=1, memory[MAR[8:0]] <= MDR. Read and write are asynchronous/combinational.
- Select-and-encode register fields: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
  - The selected index is Ra if Gra, else Rb if Grb, else Rc if Grc.
  - Rin loads the selected register from the bus.
  - Rout drives the selected register onto the bus.
  - BAout behaves like Rout except that R0 drives 0.
- Cout drives IR[18:0], sign-extended to 32 bits.
- ALU: A=Y, B=bus, result goes to Z when Zin. Codes:
  - 0 ADD; 1 SUB (A−B); 2 AND; 3 OR.
  - 4 SHR (A>>B[4:0]); 5 SHRA; 6 SHL; 7 ROR; 8 ROL.
  - 9 NEG(B); 10 NOT(B); 11 MUL (optional); 12 INC (B+1).
  - All other codes produce 0.
  - Arithmetic wraps mod 2^32.
- CONin: CON <= condition on the bus per IR[20:19]: 00 =0, 01 ≠0, 10 ≥0 (sign bit 0), 11 <0.
- OutportIn: outport register <= bus. The inport register continuously samples inport_data; InPortOut drives it onto the bus.
- Bus value X/Z: registers load whatever is presented; no sanitising.

Optional Feature:
- Macro: DATAPATH2_MUL_EN.
- Defined: OpCode 11 = signed 32×32 multiply; Z gets the low 32 bits of the product.
- Undefined: OpCode 11 yields 0 and no multiplier is synthesised.

Decomposition:
- Shared package datapath2_pkg holds:
  - ALU opcode localparams (ADD..INC);
  - bus-source priority constants;
  - IR field bit positions;
  - CON condition codes.
- One natural sub-module: datapath2_alu (combinational; A, B, OpCode -> 32-bit result).

Test Plan:
- clr low -> PC, IR, Z, R2 and outport_data all read 0; release clr -> values held.
- MBIout with manualBusInput=0, PCin, MARin -> PC=0, MAR=0. Then manualBusInput=0xB9600000 with MDRin+Write -> mem[0]=0xB9600000. Then MDRout+IRin -> IR=0xB9600000.
- IR=0xB9600000, manualBusInput=1, MBIout+Gra+Rin -> R2=1 (Ra=2) and R12 unchanged.
- Fetch with PC=0 and MAR/IR corrupted:
  - PCout+MARin+Zin with OpCode=12 -> MAR=0, Z=1;
  - Zlowout+PCin -> PC=1;
  - Read+MDRin -> MDR=0xB9600000;
  - MDRout+IRin -> IR=0xB9600000.
- Gra+Rout+OutportIn with R2=1 -> outport_data=1.
- Y=5, bus=3: OpCode 1 -> Z=2; OpCode 9 -> Z=0xFFFFFFFD. IR[20:19]=01 with bus=0 and CONin -> con_out=0.
